// File: rtl/serial_borrow_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_borrow_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
// One full-subtractor cell plus operand/result shift registers; results commit in FIN.
module serial_borrow_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_borrow_subtractor_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] pd;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             br_nxt;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             zero_q;

  function automatic logic fs_diff(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  assign d_bit  = fs_diff(sa[0], sb[0], br);
  assign br_nxt = fs_borrow(sa[0], sb[0], br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      pd     <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            br    <= bus.bin;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            cnt   <= '0;
          end
        end
        RUN: begin
          // Operands drain from bit 0; the result fills in from the MSB side.
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          pd  <= {d_bit, pd[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          diff_q <= pd;
          bout_q <= br;
          ovf_q  <= (a_msb != b_msb) && (pd[WIDTH-1] != a_msb);
          zero_q <= (pd == '0);
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed bench for serial_borrow_subtractor: vector table plus handshake/reset sequences.
module tb_serial_borrow_subtractor;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_borrow_subtractor_if #(.WIDTH(W)) bus ();

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Launch one operation and return at the negedge where done is first seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output int lat, output int busy_cyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 0;
    busy_cyc  = 0;
    while (!bus.done && lat < 50) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busy_cyc;
    int dones;
    int gap;
    logic hold_ok;
    logic [W-1:0] cap;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_flags", {bus.bout, bus.ovf, bus.zero}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, busy_cyc);
      check($sformatf("v%0d_latency", i), lat, W + 1);
      check($sformatf("v%0d_busy_cycles", i), busy_cyc, W + 1);
      check($sformatf("v%0d_busy_in_done", i), bus.busy, 0);
      check($sformatf("v%0d_diff", i), bus.diff, vecs[i].diff);
      check($sformatf("v%0d_bout", i), bus.bout, vecs[i].bout);
      check($sformatf("v%0d_ovf", i), bus.ovf, vecs[i].ovf);
      check($sformatf("v%0d_zero", i), bus.zero, vecs[i].zero);
      @(negedge clk);
      check($sformatf("v%0d_done_single", i), bus.done, 0);
      check($sformatf("v%0d_diff_hold", i), bus.diff, vecs[i].diff);
    end

    // Start while busy is ignored; operand changes mid-run do not leak in.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h20; bus.b = 8'h01; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00; bus.bin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    cap   = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        cap = bus.diff;
      end
    end
    check("busy_start_done_count", dones, 1);
    check("busy_start_diff", cap, 8'h1F);
    check("busy_start_idle", bus.busy, 0);

    // Back-to-back: second start issued in the done cycle.
    do_op(8'h05, 8'h03, 1'b0, lat, busy_cyc);
    check("b2b_first_diff", bus.diff, 8'h02);
    bus.start = 1'b1; bus.a = 8'h44; bus.b = 8'h11; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    gap     = 1;
    hold_ok = 1'b1;
    while (!bus.done && gap < 50) begin
      if (bus.diff !== 8'h02) hold_ok = 1'b0;
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", gap, W + 2);
    check("b2b_hold", hold_ok, 1);
    check("b2b_second_diff", bus.diff, 8'h33);

    // Asynchronous reset just after edge E4 of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h50; bus.b = 8'h10; bus.bin = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_diff", bus.diff, 0);
    check("arst_flags", {bus.done, bus.bout, bus.ovf, bus.zero}, 0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("arst_no_done", dones, 0);
    do_op(8'h09, 8'h04, 1'b0, lat, busy_cyc);
    check("post_rst_latency", lat, W + 1);
    check("post_rst_diff", bus.diff, 8'h05);
    check("post_rst_flags", {bus.bout, bus.ovf, bus.zero}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
